issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 117 +++++++++++
 tb/tb_issue_scoreboard.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register in-flight write counters that raise RAW/WAW
// stalls for the D->E issue point and turn a taken branch into F/D flushes.
module issue_scoreboard #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rs1,
    input  logic [4:0]  i_issue_rs2,
    input  logic        i_use_rs1,
    input  logic        i_use_rs2,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_issue_rd_wren,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_br_taken,
    output logic        o_stall_pc,
    output logic        o_stall_f,
    output logic        o_stall_d,
    output logic        o_flush_f,
    output logic        o_flush_d,
    output logic        o_flush_e,
    output logic [31:0] o_busy,
    output logic [31:0] o_stall_cnt,
    output logic        o_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic [CNT_W-1:0] cnt_v [32];
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] c_rs1, c_rs2, c_rd, c_wb;
    logic             clr1, clr2, raw_hit, waw_full, hazard, issue_ok;
    logic             wb_hit, dec_ok;

    // r0 reads as a permanently empty counter so it can never raise a hazard
    always_comb begin
        cnt_v[0] = '0;
        for (int r = 1; r < 32; r++) cnt_v[r] = cnt_q[r];
    end

    assign c_rs1 = cnt_v[i_issue_rs1];
    assign c_rs2 = cnt_v[i_issue_rs2];
    assign c_rd  = cnt_v[i_issue_rd];
    assign c_wb  = cnt_v[i_wb_rd];

    assign clr1 = (WB_BYPASS != 0) && i_wb_valid && (i_wb_rd == i_issue_rs1) && (c_rs1 == CNT_ONE);
    assign clr2 = (WB_BYPASS != 0) && i_wb_valid && (i_wb_rd == i_issue_rs2) && (c_rs2 == CNT_ONE);

    assign raw_hit  = (i_use_rs1 && (i_issue_rs1 != 5'd0) && (c_rs1 != '0) && !clr1) ||
                      (i_use_rs2 && (i_issue_rs2 != 5'd0) && (c_rs2 != '0) && !clr2);
    assign waw_full = i_issue_rd_wren && (i_issue_rd != 5'd0) && (c_rd == CNT_MAX) &&
                      !(i_wb_valid && (i_wb_rd == i_issue_rd));
    assign hazard   = i_issue_valid && !i_br_taken && (raw_hit || waw_full);
    assign issue_ok = i_issue_valid && !hazard && !i_br_taken && i_issue_rd_wren && (i_issue_rd != 5'd0);

    assign wb_hit = i_wb_valid && (i_wb_rd != 5'd0);
    assign dec_ok = wb_hit && (c_wb != '0);

    always_comb begin
        o_stall_pc = 1'b0;
        o_stall_f  = 1'b0;
        o_stall_d  = 1'b0;
        o_flush_f  = 1'b0;
        o_flush_d  = 1'b0;
        o_flush_e  = 1'b0;
        if (i_br_taken) begin
            o_flush_f = 1'b1;
            o_flush_d = 1'b1;
        end else if (hazard) begin
            o_stall_pc = 1'b1;
            o_stall_f  = 1'b1;
            o_stall_d  = 1'b1;
            o_flush_e  = 1'b1;
        end
    end

    always_comb begin
        o_busy = '0;
        for (int r = 1; r < 32; r++) o_busy[r] = (cnt_q[r] != '0);
    end

    // Simultaneous issue and retire on one register cancel out
    always_comb begin
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_ok && (i_issue_rd == 5'(r)) && !(dec_ok && (i_wb_rd == 5'(r))))
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            else if (dec_ok && (i_wb_rd == 5'(r)) && !(issue_ok && (i_issue_rd == 5'(r))))
                cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
    end

    assign stall_cnt_d = stall_cnt_q + {31'd0, hazard};
    assign err_d       = err_q || (wb_hit && (c_wb == '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_d[r];
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: a bypass and a non-bypass instance share stimulus
// and are compared each cycle against a counter-array reference model.
module tb_issue_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       valid, use1, use2, wren, wbv, br;
    logic [4:0] rs1, rs2, rd, wbrd;

    logic        a_spc, a_sf, a_sd, a_ff, a_fd, a_fe, a_err;
    logic [31:0] a_busy, a_scnt;
    logic        b_spc, b_sf, b_sd, b_ff, b_fd, b_fe, b_err;
    logic [31:0] b_busy, b_scnt;

    issue_scoreboard #(.WB_BYPASS(1), .CNT_W(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(valid),
        .i_issue_rs1(rs1), .i_issue_rs2(rs2), .i_use_rs1(use1), .i_use_rs2(use2),
        .i_issue_rd(rd), .i_issue_rd_wren(wren), .i_wb_valid(wbv), .i_wb_rd(wbrd),
        .i_br_taken(br), .o_stall_pc(a_spc), .o_stall_f(a_sf), .o_stall_d(a_sd),
        .o_flush_f(a_ff), .o_flush_d(a_fd), .o_flush_e(a_fe), .o_busy(a_busy),
        .o_stall_cnt(a_scnt), .o_err(a_err));

    issue_scoreboard #(.WB_BYPASS(0), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_issue_valid(valid),
        .i_issue_rs1(rs1), .i_issue_rs2(rs2), .i_use_rs1(use1), .i_use_rs2(use2),
        .i_issue_rd(rd), .i_issue_rd_wren(wren), .i_wb_valid(wbv), .i_wb_rd(wbrd),
        .i_br_taken(br), .o_stall_pc(b_spc), .o_stall_f(b_sf), .o_stall_d(b_sd),
        .o_flush_f(b_ff), .o_flush_d(b_fd), .o_flush_e(b_fe), .o_busy(b_busy),
        .o_stall_cnt(b_scnt), .o_err(b_err));

    int nchk = 0;
    int nerr = 0;

    // Model state: index 0 = bypass instance, 1 = no-bypass instance
    localparam int MAXC = 3;
    int        mc    [2][32];
    bit        merr  [2];
    bit [31:0] mscnt [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_src_blocks(input int k, input logic u, input logic [4:0] rs);
        if (!u || rs == 5'd0 || mc[k][rs] == 0) return 1'b0;
        if (k == 0 && wbv && wbrd == rs && mc[k][rs] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_hazard(input int k);
        bit waw;
        waw = wren && rd != 5'd0 && mc[k][rd] == MAXC && !(wbv && wbrd == rd);
        return valid && !br && (m_src_blocks(k, use1, rs1) || m_src_blocks(k, use2, rs2) || waw);
    endfunction

    function automatic logic [31:0] m_busy(input int k);
        logic [31:0] b = '0;
        for (int r = 1; r < 32; r++) b[r] = (mc[k][r] != 0);
        return b;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) mc[k][r] = 0;
            merr[k]  = 1'b0;
            mscnt[k] = '0;
        end
    endtask

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            bit h, iss;
            h   = m_hazard(k);
            iss = valid && !h && !br && wren && rd != 5'd0;
            if (wbv && wbrd != 5'd0) begin
                if (mc[k][wbrd] == 0) merr[k] = 1'b1;
                else mc[k][wbrd] = mc[k][wbrd] - 1;
            end
            if (iss) mc[k][rd] = mc[k][rd] + 1;
            if (h) mscnt[k] = mscnt[k] + 32'd1;
        end
    endtask

    task automatic check_outs(input string n, input int k,
                              input logic spc, input logic sf, input logic sd,
                              input logic ff, input logic fd, input logic fe,
                              input logic [31:0] busy, input logic [31:0] scnt, input logic err);
        bit h;
        h = m_hazard(k);
        chk({n, "_stall_pc"}, spc, h);
        chk({n, "_stall_f"}, sf, h);
        chk({n, "_stall_d"}, sd, h);
        chk({n, "_flush_e"}, fe, h);
        chk({n, "_flush_f"}, ff, br);
        chk({n, "_flush_d"}, fd, br);
        chk({n, "_busy"}, busy, m_busy(k));
        chk({n, "_stall_cnt"}, scnt, mscnt[k]);
        chk({n, "_err"}, err, merr[k]);
    endtask

    // Called at the falling edge: compare both instances, then cross the rising edge
    task automatic check_and_step();
        check_outs("A", 0, a_spc, a_sf, a_sd, a_ff, a_fd, a_fe, a_busy, a_scnt, a_err);
        check_outs("B", 1, b_spc, b_sf, b_sd, b_ff, b_fd, b_fe, b_busy, b_scnt, b_err);
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] s1, input logic u1,
                          input logic [4:0] s2, input logic u2, input logic [4:0] d,
                          input logic w, input logic wv, input logic [4:0] wd, input logic b);
        valid = v; rs1 = s1; use1 = u1; rs2 = s2; use2 = u2;
        rd = d; wren = w; wbv = wv; wbrd = wd; br = b;
    endtask

    // Asserts reset between edges and checks that state clears before any edge
    task automatic do_reset(input string n);
        rst_n = 1'b0;
        #2;
        chk({n, "_rst_busyA"}, a_busy, 32'd0);
        chk({n, "_rst_stallA"}, a_sd, 1'b0);
        chk({n, "_rst_flusheA"}, a_fe, 1'b0);
        chk({n, "_rst_scntA"}, a_scnt, 32'd0);
        chk({n, "_rst_errA"}, a_err, 1'b0);
        chk({n, "_rst_busyB"}, b_busy, 32'd0);
        chk({n, "_rst_stallB"}, b_sd, 1'b0);
        chk({n, "_rst_scntB"}, b_scnt, 32'd0);
        chk({n, "_rst_errB"}, b_err, 1'b0);
        m_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic v; logic [4:0] s1; logic u1; logic [4:0] s2; logic u2;
        logic [4:0] d; logic w; logic wv; logic [4:0] wd; logic b;
        logic e_stall; logic e_ff; logic [31:0] e_busy; logic [31:0] e_scnt; logic e_err;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Bypass instance expectations, one row per cycle
        tbl[0]  = '{1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0, 0, 0, 32'h00, 32'd0, 0};
        tbl[1]  = '{1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 5'd0, 0, 1, 0, 32'h20, 32'd0, 0};
        tbl[2]  = '{1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 5'd0, 0, 1, 0, 32'h20, 32'd1, 0};
        tbl[3]  = '{1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 1, 5'd5, 0, 0, 0, 32'h20, 32'd2, 0};
        tbl[4]  = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h40, 32'd2, 0};
        tbl[5]  = '{1, 5'd6, 1, 5'd0, 0, 5'd8, 1, 0, 5'd0, 1, 0, 1, 32'h40, 32'd2, 0};
        tbl[6]  = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd6, 0, 0, 0, 32'h40, 32'd2, 0};
        tbl[7]  = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0, 0, 32'h00, 32'd2, 0};
        tbl[8]  = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h00, 32'd2, 1};
        tbl[9]  = '{1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0, 0, 32'h00, 32'd2, 1};
        tbl[10] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 32'h00, 32'd2, 1};

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        #3;
        chk("init_busy", a_busy, 32'd0);
        chk("init_scnt", a_scnt, 32'd0);
        chk("init_err", a_err, 1'b0);
        chk("init_stall", a_sd, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].v, tbl[i].s1, tbl[i].u1, tbl[i].s2, tbl[i].u2,
                   tbl[i].d, tbl[i].w, tbl[i].wv, tbl[i].wd, tbl[i].b);
            @(negedge clk);
            chk($sformatf("tbl%0d_stall_d", i), a_sd, tbl[i].e_stall);
            chk($sformatf("tbl%0d_stall_pc", i), a_spc, tbl[i].e_stall);
            chk($sformatf("tbl%0d_flush_e", i), a_fe, tbl[i].e_stall);
            chk($sformatf("tbl%0d_flush_f", i), a_ff, tbl[i].e_ff);
            chk($sformatf("tbl%0d_flush_d", i), a_fd, tbl[i].e_ff);
            chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_scnt", i), a_scnt, tbl[i].e_scnt);
            chk($sformatf("tbl%0d_err", i), a_err, tbl[i].e_err);
            check_and_step();
        end

        // Writeback bypass versus one extra stall cycle without it
        do_reset("byp");
        set_in(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
        @(negedge clk); check_and_step();
        set_in(1, 5'd5, 1, 0, 0, 0, 0, 1, 5'd5, 0);
        @(negedge clk);
        chk("byp1_wb_cycle_stall", a_sd, 1'b0);
        chk("byp0_wb_cycle_stall", b_sd, 1'b1);
        check_and_step();
        set_in(1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("byp0_after_wb_stall", b_sd, 1'b0);
        chk("byp0_scnt", b_scnt, 32'd1);
        chk("byp1_scnt", a_scnt, 32'd0);
        check_and_step();

        // WAW saturation on r7
        do_reset("waw");
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
            @(negedge clk); check_and_step();
        end
        set_in(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
        @(negedge clk);
        chk("waw_full_stall", a_sd, 1'b1);
        check_and_step();
        set_in(1, 0, 0, 0, 0, 5'd7, 1, 1, 5'd7, 0);
        @(negedge clk);
        chk("waw_wb_release", a_sd, 1'b0);
        check_and_step();
        set_in(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
        @(negedge clk);
        chk("waw_cnt_still_full", a_sd, 1'b1);
        check_and_step();

        // Reset dropped in the middle of a RAW stall
        do_reset("pre");
        set_in(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
        @(negedge clk); check_and_step();
        set_in(1, 5'd5, 1, 0, 0, 5'd6, 1, 0, 0, 0);
        @(negedge clk); check_and_step();
        @(negedge clk); check_and_step();
        chk("mid_stall_active", a_sd, 1'b1);
        chk("mid_stall_scnt", a_scnt, 32'd2);
        do_reset("mid");

        // Randomized traffic on a small register window
        for (int i = 0; i < 2000; i++) begin
            int q[$];
            if (i == 1000) do_reset("rnd");
            valid = ($urandom_range(0, 9) < 8);
            rs1   = 5'($urandom_range(0, 7));
            rs2   = 5'($urandom_range(0, 7));
            use1  = 1'($urandom_range(0, 1));
            use2  = 1'($urandom_range(0, 1));
            rd    = 5'($urandom_range(0, 7));
            wren  = ($urandom_range(0, 3) != 0);
            wbv   = ($urandom_range(0, 9) < 5);
            br    = ($urandom_range(0, 15) == 0);
            for (int r = 1; r < 32; r++) if (mc[0][r] > 0) q.push_back(r);
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                wbrd = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                wbrd = 5'($urandom_range(0, 9));
            @(negedge clk);
            check_and_step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
